// File: rtl/filter_seq.sv
// Frame sequencer: streams NUM_PIX source pixels through a fixed-latency colour filter and
// writes them back at matching addresses. Optional raw-pixel path: FILTER_SEQ_BYPASS_EN.
module filter_seq #(
    parameter int unsigned NUM_PIX  = 76800,
    parameter int unsigned ADDR_W   = 17,
    parameter int unsigned FILT_LAT = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              abort_i,
`ifdef FILTER_SEQ_BYPASS_EN
    input  logic              bypass_i,
`endif
    output logic              busy_o,
    output logic              done_o,
    output logic              aborted_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [23:0]       rd_data_i,
    output logic [7:0]        f_r_in_o,
    output logic [7:0]        f_g_in_o,
    output logic [7:0]        f_b_in_o,
    input  logic [7:0]        f_r_out_i,
    input  logic [7:0]        f_g_out_i,
    input  logic [7:0]        f_b_out_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [23:0]       wr_data_o
);

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StFin} state_e;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_PIX - 1);

    state_e                       state_q, state_d;
    logic [ADDR_W-1:0]            rd_addr_q, rd_addr_d;
    logic                         abort_pend_q, abort_pend_d;
    logic                         aborted_q, aborted_d;
    logic                         rd_en;
    logic                         upstream_empty;
    logic [FILT_LAT:0]            vld_q;
    logic [FILT_LAT:0][ADDR_W-1:0] adr_q;

    // The last stage is writing this cycle, so the line is empty next cycle once
    // every earlier stage is clear.
    always_comb begin
        upstream_empty = 1'b1;
        for (int unsigned i = 0; i < FILT_LAT; i++) begin
            if (vld_q[i]) upstream_empty = 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        rd_addr_d    = rd_addr_q;
        abort_pend_d = abort_pend_q;
        aborted_d    = aborted_q;
        rd_en        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d      = StRead;
                    rd_addr_d    = '0;
                    abort_pend_d = 1'b0;
                    aborted_d    = 1'b0;
                end
            end
            StRead: begin
                if (abort_i) begin
                    state_d      = StDrain;
                    abort_pend_d = 1'b1;
                end else begin
                    rd_en = 1'b1;
                    if (rd_addr_q == LastAddr) state_d = StDrain;
                    else rd_addr_d = rd_addr_q + 1'b1;
                end
            end
            StDrain: begin
                if (upstream_empty) begin
                    state_d   = StFin;
                    aborted_d = abort_pend_q;
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            rd_addr_q    <= '0;
            abort_pend_q <= 1'b0;
            aborted_q    <= 1'b0;
            vld_q        <= '0;
            adr_q        <= '0;
        end else begin
            state_q      <= state_d;
            rd_addr_q    <= rd_addr_d;
            abort_pend_q <= abort_pend_d;
            aborted_q    <= aborted_d;
            vld_q[0]     <= rd_en;
            adr_q[0]     <= rd_addr_q;
            for (int unsigned i = 1; i <= FILT_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                adr_q[i] <= adr_q[i-1];
            end
        end
    end

`ifdef FILTER_SEQ_BYPASS_EN
    logic                     bypass_q;
    logic [FILT_LAT-1:0][23:0] raw_q;

    // Raw pixels trail the filter by the same latency so timing is mode-independent.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bypass_q <= 1'b0;
            raw_q    <= '0;
        end else begin
            if (state_q == StIdle && start_i) bypass_q <= bypass_i;
            raw_q[0] <= rd_data_i;
            for (int unsigned i = 1; i < FILT_LAT; i++) begin
                raw_q[i] <= raw_q[i-1];
            end
        end
    end
`endif

    always_comb begin
        wr_data_o = '0;
        if (vld_q[FILT_LAT]) wr_data_o = {f_r_out_i, f_g_out_i, f_b_out_i};
`ifdef FILTER_SEQ_BYPASS_EN
        if (vld_q[FILT_LAT] && bypass_q) wr_data_o = raw_q[FILT_LAT-1];
`endif
    end

    assign busy_o    = (state_q == StRead) || (state_q == StDrain);
    assign done_o    = (state_q == StFin);
    assign aborted_o = aborted_q;
    assign rd_en_o   = rd_en;
    assign rd_addr_o = rd_addr_q;
    assign f_r_in_o  = rd_data_i[23:16];
    assign f_g_in_o  = rd_data_i[15:8];
    assign f_b_in_o  = rd_data_i[7:0];
    assign wr_en_o   = vld_q[FILT_LAT];
    assign wr_addr_o = adr_q[FILT_LAT];

endmodule

// File: tb/tb_filter_seq.sv
// Bench for filter_seq: an 8-pixel frame with a behavioural sepia filter attached, plus a
// 1-pixel instance for the single-pixel boundary.
module tb_filter_seq;

    localparam int unsigned N   = 8;
    localparam int unsigned AW  = 3;
    localparam int unsigned LAT = 4;
`ifdef FILTER_SEQ_BYPASS_EN
    localparam bit HasBypass = 1'b1;
`else
    localparam bit HasBypass = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, bypass = 1'b0, start1 = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          busy, done, aborted, rd_en, wr_en;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [23:0]   rd_data = '0, wr_data;
    logic [7:0]    f_r_in, f_g_in, f_b_in, f_r_out, f_g_out, f_b_out;

    filter_seq #(.NUM_PIX(N), .ADDR_W(AW), .FILT_LAT(LAT)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
`ifdef FILTER_SEQ_BYPASS_EN
        .bypass_i(bypass),
`endif
        .busy_o(busy), .done_o(done), .aborted_o(aborted), .rd_en_o(rd_en),
        .rd_addr_o(rd_addr), .rd_data_i(rd_data),
        .f_r_in_o(f_r_in), .f_g_in_o(f_g_in), .f_b_in_o(f_b_in),
        .f_r_out_i(f_r_out), .f_g_out_i(f_g_out), .f_b_out_i(f_b_out),
        .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data)
    );

    logic        busy1, done1, aborted1, rd_en1, wr_en1;
    logic [3:0]  rd_addr1, wr_addr1;
    logic [23:0] wr_data1;
    logic [7:0]  r1, g1, b1;

    filter_seq #(.NUM_PIX(1), .ADDR_W(4), .FILT_LAT(LAT)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .abort_i(1'b0),
`ifdef FILTER_SEQ_BYPASS_EN
        .bypass_i(1'b0),
`endif
        .busy_o(busy1), .done_o(done1), .aborted_o(aborted1), .rd_en_o(rd_en1),
        .rd_addr_o(rd_addr1), .rd_data_i(24'h0),
        .f_r_in_o(r1), .f_g_in_o(g1), .f_b_in_o(b1),
        .f_r_out_i(8'h0), .f_g_out_i(8'h0), .f_b_out_i(8'h0),
        .wr_en_o(wr_en1), .wr_addr_o(wr_addr1), .wr_data_o(wr_data1)
    );

    // Sepia with coefficients scaled by 256, saturating at 255.
    function automatic logic [23:0] sepia(input logic [23:0] p);
        int r, g, b, ro, go, bo;
        r  = int'(p[23:16]);
        g  = int'(p[15:8]);
        b  = int'(p[7:0]);
        ro = (100 * r + 196 * g + 47 * b) / 256;
        go = (89 * r + 176 * g + 38 * b) / 256;
        bo = (70 * r + 137 * g + 31 * b) / 256;
        if (ro > 255) ro = 255;
        if (go > 255) go = 255;
        if (bo > 255) bo = 255;
        return {ro[7:0], go[7:0], bo[7:0]};
    endfunction

    // Environment: source frame store and free-running filter pipeline.
    logic [23:0] src [N];
    logic [23:0] fp [LAT];
    always @(posedge clk) if (rd_en) rd_data <= src[rd_addr];
    always @(posedge clk) begin
        fp[0] <= sepia({f_r_in, f_g_in, f_b_in});
        for (int i = 1; i < LAT; i++) fp[i] <= fp[i-1];
    end
    assign {f_r_out, f_g_out, f_b_out} = fp[LAT-1];

    typedef struct {int cyc; int addr; logic [23:0] data;} ev_t;
    ev_t wq[$], rq[$];
    int  done_q[$], busy_cnt;
    int  w1q[$], r1q[$], d1q[$];

    always @(negedge clk) begin
        if (wr_en) wq.push_back('{cyc, int'(wr_addr), wr_data});
        if (rd_en) rq.push_back('{cyc, int'(rd_addr), 24'h0});
        if (done) done_q.push_back(cyc);
        if (busy) busy_cnt++;
        if (wr_en1) w1q.push_back(cyc);
        if (rd_en1) r1q.push_back(cyc);
        if (done1) d1q.push_back(cyc);
    end

    int checks = 0, errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    function automatic logic [23:0] exp_pix(input int a, input bit byp);
        return (HasBypass && byp) ? src[a] : sepia(src[a]);
    endfunction

    task automatic fill(input int pattern);
        for (int i = 0; i < N; i++) begin
            case (pattern)
                0:       src[i] = {8'd100, 8'd100, 8'd100};
                3:       src[i] = {8'd10, 8'd20, 8'd30};
                default: src[i] = 24'($urandom);
            endcase
        end
        if (pattern == 1) src[3] = 24'hFFFFFF;
    endtask

    // Runs one pass: start in cycle s, abort/restart at given offsets, 24 cycles total.
    task automatic run_pass(input int abort_off, input int restart_off, input bit byp,
                            output int s);
        wq.delete(); rq.delete(); done_q.delete(); busy_cnt = 0;
        @(posedge clk); #1;
        s = cyc; start = 1'b1; bypass = byp; abort = (abort_off == 0);
        for (int off = 1; off <= 24; off++) begin
            @(posedge clk); #1;
            start  = (off == restart_off);
            abort  = (off == abort_off);
            bypass = ~byp;
        end
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic check_pass(input string tag, input int s, input int nw, input int dn,
                              input bit ab, input bit byp);
        check({tag, " writes"}, wq.size(), nw);
        check({tag, " reads"}, rq.size(), nw);
        for (int i = 0; i < wq.size() && i < nw; i++) begin
            check({tag, " wr_addr"}, wq[i].addr, i);
            check({tag, " wr_cycle"}, wq[i].cyc - s, i + 6);
            check({tag, " wr_data"}, wq[i].data, exp_pix(i, byp));
        end
        for (int i = 0; i < rq.size() && i < nw; i++) begin
            check({tag, " rd_addr"}, rq[i].addr, i);
            check({tag, " rd_cycle"}, rq[i].cyc - s, i + 1);
        end
        check({tag, " done count"}, done_q.size(), 1);
        if (done_q.size() > 0) check({tag, " done cycle"}, done_q[0] - s, dn);
        check({tag, " busy cycles"}, busy_cnt, dn - 1);
        check({tag, " aborted"}, aborted, ab);
    endtask

    typedef struct {
        int abort_off; int restart_off; int pattern; bit byp;
        int exp_writes; int exp_done; bit exp_aborted;
    } vec_t;

    vec_t vecs[$];
    int   s, bad;

    initial begin
        vecs.push_back('{-1, -1, 0, 1'b0, 8, 14, 1'b0});  // nominal grey frame
        vecs.push_back('{-1, -1, 1, 1'b0, 8, 14, 1'b0});  // saturating pixel at addr 3
        vecs.push_back('{ 4, -1, 2, 1'b0, 3,  9, 1'b1});  // abort after three reads
        vecs.push_back('{ 1, -1, 2, 1'b0, 0,  3, 1'b1});  // abort on first read cycle
        vecs.push_back('{ 8, -1, 2, 1'b0, 7, 13, 1'b1});  // abort on last read cycle
        vecs.push_back('{ 9, -1, 2, 1'b0, 8, 14, 1'b0});  // abort during drain ignored
        vecs.push_back('{ 0, -1, 2, 1'b0, 8, 14, 1'b0});  // abort while idle ignored
        vecs.push_back('{-1,  3, 2, 1'b0, 8, 14, 1'b0});  // start while busy ignored
        vecs.push_back('{-1, 14, 2, 1'b0, 8, 14, 1'b0});  // start during done not queued
        vecs.push_back('{-1, -1, 3, 1'b1, 8, 14, 1'b0});  // bypass (if built in)

        // Reset and idle.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset outputs", {busy, done, aborted, rd_en, wr_en, rd_addr, wr_addr, wr_data}, 0);
        @(posedge clk); #1; rst_n = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if ({busy, done, aborted, rd_en, wr_en, rd_addr, wr_addr, wr_data} != 0) bad++;
        end
        check("idle outputs nonzero cycles", bad, 0);

        foreach (vecs[v]) begin
            fill(vecs[v].pattern);
            run_pass(vecs[v].abort_off, vecs[v].restart_off, vecs[v].byp, s);
            check_pass($sformatf("vec%0d", v), s, vecs[v].exp_writes, vecs[v].exp_done,
                       vecs[v].exp_aborted, vecs[v].byp);
            if (v == 0 && wq.size() > 0) check("grey sepia", wq[0].data, 24'h85765C);
            if (v == 1 && wq.size() > 3) check("saturated sepia", wq[3].data, 24'hFFFFED);
            if (v == 9 && HasBypass && wq.size() > 0) check("bypass raw", wq[0].data, 24'h0A141E);
        end

        // Random passes against an arithmetic model of the pass rules.
        for (int k = 0; k < 20; k++) begin
            int a, n, dn;
            bit ab;
            a = int'($urandom_range(0, 12));
            if (a > 10) a = -1;
            fill(2);
            ab = (a >= 1 && a <= int'(N));
            n  = ab ? a - 1 : int'(N);
            dn = (n > 0) ? (n - 1 + 6) + 1 : a + 2;
            run_pass(a, -1, 1'b0, s);
            check_pass($sformatf("rnd%0d", k), s, n, dn, ab, 1'b0);
        end

        // Reset mid-pass: pipeline flushed, no writes, restart from address 0.
        fill(2);
        wq.delete();
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        #1; rst_n = 1'b0;
        @(negedge clk);
        check("midpass reset outputs", {busy, done, aborted, rd_en, wr_en, rd_addr, wr_addr, wr_data}, 0);
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (12) @(posedge clk);
        check("writes after reset", wq.size(), 0);
        run_pass(-1, -1, 1'b0, s);
        check_pass("after reset", s, 8, 14, 1'b0, 1'b0);

        // Single-pixel frame.
        w1q.delete(); r1q.delete(); d1q.delete();
        @(posedge clk); #1; s = cyc; start1 = 1'b1;
        @(posedge clk); #1; start1 = 1'b0;
        repeat (12) @(posedge clk);
        check("np1 reads", r1q.size(), 1);
        check("np1 writes", w1q.size(), 1);
        check("np1 done count", d1q.size(), 1);
        if (w1q.size() > 0) check("np1 write cycle", w1q[0] - s, 6);
        if (d1q.size() > 0) check("np1 done cycle", d1q[0] - s, 7);
        check("np1 aborted", aborted1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
